// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM: register map,
// byte-lane decoding and parameter-range validation.
package pwm_pkg;

  localparam logic [6:0] ADDR_EN_OUT = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM = 7'h10;
  localparam logic [6:0] ADDR_PRESC  = 7'h20;
  localparam logic [6:0] ADDR_DUTY   = 7'h40;

  // Byte lane within an 8-register block.
  function automatic logic [2:0] byte_lane(input logic [6:0] addr);
    return addr[2:0];
  endfunction

  // Base address of the 8-register block the address falls in.
  function automatic logic [6:0] block_base(input logic [6:0] addr);
    return {addr[6:3], 3'b000};
  endfunction

  function automatic bit params_ok(input int num_ch, input int cnt_w, input int presc_w);
    return (num_ch >= 8) && (num_ch <= 64) && ((num_ch % 8) == 0) &&
           (cnt_w >= 2) && (cnt_w <= 8) && (presc_w >= 1) && (presc_w <= 8);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and PWM counter shared by all channels; emits tick and the reload strobe.
// Build option: PWM_CENTER_ALIGNED_EN makes the counter run up then down.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale,
  output logic [CNT_W-1:0]   cnt,
  output logic               tick,
  output logic               reload
);

  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_TOP  = CNT_MAX - CNT_ONE;

  logic [PRESC_W-1:0] pcnt_r, pcnt_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic               tick_s, reload_s;
`ifdef PWM_CENTER_ALIGNED_EN
  logic               dir_up_r, dir_up_nx_s;
`endif

  // Next-state: >= (not ==) lets a lowered prescale tick immediately instead of wrapping.
  always_comb begin
    tick_s    = (pcnt_r >= prescale);
    pcnt_nx_s = pcnt_r;
    cnt_nx_s  = cnt_r;
    reload_s  = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_up_nx_s = dir_up_r;
`endif
    if (tick_s) begin
      pcnt_nx_s = {PRESC_W{1'b0}};
`ifdef PWM_CENTER_ALIGNED_EN
      if (dir_up_r) begin
        cnt_nx_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_TOP) begin
          dir_up_nx_s = 1'b0;
        end else begin
          dir_up_nx_s = 1'b1;
        end
      end else begin
        cnt_nx_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          dir_up_nx_s = 1'b1;
          reload_s    = 1'b1;
        end else begin
          dir_up_nx_s = 1'b0;
          reload_s    = 1'b0;
        end
      end
`else
      if (cnt_r == CNT_TOP) begin
        cnt_nx_s = {CNT_W{1'b0}};
        reload_s = 1'b1;
      end else begin
        cnt_nx_s = cnt_r + CNT_ONE;
        reload_s = 1'b0;
      end
`endif
    end else begin
      pcnt_nx_s = pcnt_r + PCNT_ONE;
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r <= {PRESC_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
`ifdef PWM_CENTER_ALIGNED_EN
      dir_up_r <= 1'b1;
`endif
    end else begin
      pcnt_r <= pcnt_nx_s;
      cnt_r  <= cnt_nx_s;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_up_r <= dir_up_nx_s;
`endif
    end
  end

  assign cnt    = cnt_r;
  assign tick   = tick_s;
  assign reload = reload_s;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM: byte-wide register file, double-buffered duty and registered outputs.
// Build option: PWM_CENTER_ALIGNED_EN selects the center-aligned timebase.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_end
);

  localparam int NUM_LANES = NUM_CH / 8;

  if (!params_ok(NUM_CH, CNT_W, PRESC_W)) begin : g_param_err
    $error("pwm_multi_channel: parameter out of range");
  end

  logic [NUM_CH-1:0]  en_out_r, en_pwm_r, pwm_s, out_r;
  logic [PRESC_W-1:0] prescale_r;
  logic [CNT_W-1:0]   duty_shadow_r [NUM_CH];
  logic [CNT_W-1:0]   duty_active_r [NUM_CH];
  logic [NUM_LANES-1:0] en_out_we_s, en_pwm_we_s;
  logic [NUM_CH-1:0]  duty_we_s;
  logic               presc_we_s, period_end_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               tick_s, reload_s;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale_r),
    .cnt      (cnt_s),
    .tick     (tick_s),
    .reload   (reload_s)
  );

  // Address decode into per-register write enables; unmapped addresses fall through.
  always_comb begin
    en_out_we_s = {NUM_LANES{1'b0}};
    en_pwm_we_s = {NUM_LANES{1'b0}};
    duty_we_s   = {NUM_CH{1'b0}};
    presc_we_s  = 1'b0;
    if (wr_en) begin
      if (wr_addr[6]) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          duty_we_s[ch] = (int'(wr_addr[5:0]) == ch);
        end
      end else begin
        case (block_base(wr_addr))
          ADDR_EN_OUT: begin
            for (int k = 0; k < NUM_LANES; k++) begin
              en_out_we_s[k] = (int'(byte_lane(wr_addr)) == k);
            end
          end
          ADDR_EN_PWM: begin
            for (int k = 0; k < NUM_LANES; k++) begin
              en_pwm_we_s[k] = (int'(byte_lane(wr_addr)) == k);
            end
          end
          ADDR_PRESC: presc_we_s = (byte_lane(wr_addr) == 3'd0);
          default:    presc_we_s = 1'b0;
        endcase
      end
    end else begin
      presc_we_s = 1'b0;
    end
  end

  // Enable and prescale registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_r   <= {NUM_CH{1'b0}};
      en_pwm_r   <= {NUM_CH{1'b0}};
      prescale_r <= {PRESC_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (en_out_we_s[k]) en_out_r[8*k +: 8] <= wr_data;
        if (en_pwm_we_s[k]) en_pwm_r[8*k +: 8] <= wr_data;
      end
      if (presc_we_s) prescale_r <= wr_data[PRESC_W-1:0];
    end
  end

  // Shadow/active duty; a write on the reload cycle goes straight to the active set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        duty_shadow_r[ch] <= {CNT_W{1'b0}};
        duty_active_r[ch] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (duty_we_s[ch]) duty_shadow_r[ch] <= wr_data[CNT_W-1:0];
        if (reload_s) begin
          duty_active_r[ch] <= duty_we_s[ch] ? wr_data[CNT_W-1:0] : duty_shadow_r[ch];
        end
      end
    end
  end

  // Per-channel compare.
  always_comb begin
    pwm_s = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pwm_s[ch] = (cnt_s < duty_active_r[ch]);
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r        <= {NUM_CH{1'b0}};
      period_end_r <= 1'b0;
    end else begin
      out_r        <= en_out_r & (~en_pwm_r | pwm_s);
      period_end_r <= tick_s & reload_s;
    end
  end

  assign out        = out_r;
  assign period_end = period_end_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: per-cycle reference model plus
// table vectors and directed duty/reload/prescaler/reset sequences.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int MAXV    = (1 << CNT_W) - 1;
`ifdef PWM_CENTER_ALIGNED_EN
  localparam int PERIOD  = 2 * MAXV;
`else
  localparam int PERIOD  = MAXV;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [6:0]        wr_addr = 7'h00;
  logic [7:0]        wr_data = 8'h00;
  logic [NUM_CH-1:0] out;
  logic              period_end;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: ticks since reset, clocks since last tick, registers.
  int                m_t, m_pcnt, m_presc;
  logic [NUM_CH-1:0] m_en_out, m_en_pwm, m_out;
  logic              m_pe;
  int                m_shadow [NUM_CH];
  int                m_active [NUM_CH];

  typedef struct {
    logic [6:0]        addr;
    logic [7:0]        data;
    logic [NUM_CH-1:0] exp;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out        (out),
    .period_end (period_end)
  );

  // Counter value after t ticks.
  function automatic int cnt_of(input int t);
    int m;
    m = t % PERIOD;
`ifdef PWM_CENTER_ALIGNED_EN
    return (m <= MAXV) ? m : PERIOD - m;
`else
    return m;
`endif
  endfunction

  function automatic int exp_high(input int duty, input int n);
    int h = 0;
    for (int t = 0; t < n; t++) if (cnt_of(t) < duty) h++;
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pcnt = 0; m_presc = 0;
    m_en_out = '0; m_en_pwm = '0; m_out = '0; m_pe = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_shadow[ch] = 0;
      m_active[ch] = 0;
    end
  endtask

  task automatic model_write(input int a, input int d);
    if (a < NUM_CH / 8) m_en_out[8*a +: 8] = 8'(d);
    else if (a >= 16 && a < 16 + NUM_CH / 8) m_en_pwm[8*(a-16) +: 8] = 8'(d);
    else if (a == 32) m_presc = d % (1 << PRESC_W);
    else if (a >= 64 && a < 64 + NUM_CH) m_shadow[a-64] = d % (1 << CNT_W);
  endtask

  task automatic model_step();
    bit tk, rl;
    int c;
    logic [NUM_CH-1:0] pwm;
    tk = (m_pcnt >= m_presc);
    c  = cnt_of(m_t);
    for (int ch = 0; ch < NUM_CH; ch++) pwm[ch] = (c < m_active[ch]);
    m_out = m_en_out & (~m_en_pwm | pwm);
    rl = tk && (cnt_of(m_t + 1) == 0);
    if (tk) begin
      m_t++;
      m_pcnt = 0;
    end else begin
      m_pcnt++;
    end
    if (wr_en) model_write(int'(wr_addr), int'(wr_data));
    if (rl) for (int ch = 0; ch < NUM_CH; ch++) m_active[ch] = m_shadow[ch];
    m_pe = rl;
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic cyc();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check("out", out, m_out);
    check("period_end", period_end, m_pe);
  endtask

  task automatic write(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_pe(input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (period_end !== 1'b1 && n < budget);
    check("wait_period_end", period_end, 1'b1);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      hi += int'(out[ch]);
    end
  endtask

  initial begin
    int hi, n;
    vecs[0] = '{7'h00, 8'h01, 16'h0001};
    vecs[1] = '{7'h01, 8'h80, 16'h8001};
    vecs[2] = '{7'h10, 8'h01, 16'h8000};
    vecs[3] = '{7'h11, 8'h80, 16'h0000};
    vecs[4] = '{7'h02, 8'hFF, 16'h0000};
    vecs[5] = '{7'h10, 8'h00, 16'h0001};
    vecs[6] = '{7'h11, 8'h00, 16'h8001};
    vecs[7] = '{7'h00, 8'h00, 16'h8000};
    vecs[8] = '{7'h01, 8'h00, 16'h0000};

    model_reset();
    cyc(); cyc();
    check("reset_out", out, 16'h0000);
    check("reset_period_end", period_end, 1'b0);
    rst = 1'b0;

    // All channels enabled at duty 0x80, then reset mid-run.
    write(ADDR_EN_OUT, 8'hFF); write(ADDR_EN_OUT + 7'd1, 8'hFF);
    write(ADDR_EN_PWM, 8'hFF); write(ADDR_EN_PWM + 7'd1, 8'hFF);
    for (int ch = 0; ch < NUM_CH; ch++) write(ADDR_DUTY + 7'(ch), 8'h80);
    wait_pe(PERIOD + 20);
    for (int i = 0; i < 10; i++) cyc();
    check("all_on_before_reset", out, 16'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", out, 16'h0000);
    check("async_reset_period_end", period_end, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("out_after_reset", out, 16'h0000);
    end

    // Static enable/PWM-enable vectors with all duties at 0.
    for (int i = 0; i < 9; i++) begin
      write(vecs[i].addr, vecs[i].data);
      cyc();
      check("table_out", out, vecs[i].exp);
    end

    // Duty cycle on channel 3 at prescale 0.
    write(ADDR_EN_OUT, 8'h28); write(ADDR_EN_PWM, 8'h28);
    write(ADDR_DUTY + 7'd3, 8'h40);
    wait_pe(PERIOD + 2);
    count_high(3, PERIOD, hi);
    check("duty_40_high", hi, exp_high(8'h40, PERIOD));
    write(ADDR_DUTY + 7'd3, 8'h00);
    wait_pe(PERIOD + 2);
    count_high(3, PERIOD, hi);
    check("duty_00_high", hi, 0);
    write(ADDR_DUTY + 7'd3, 8'hFF);
    wait_pe(PERIOD + 2);
    count_high(3, PERIOD, hi);
    check("duty_ff_high", hi, PERIOD);

    // Shadow reload on channel 5.
    write(ADDR_DUTY + 7'd5, 8'h80);
    wait_pe(PERIOD + 2);
    for (int i = 0; i < 100; i++) cyc();
    write(ADDR_DUTY + 7'd5, 8'h10);
    cyc();
    check("old_duty_kept", out[5], 1'b1);
    wait_pe(PERIOD + 2);
    count_high(5, PERIOD - 1, hi);
    check("new_duty_high", hi, exp_high(8'h10, PERIOD - 1));
    write(ADDR_DUTY + 7'd5, 8'h20);
    check("reload_write_pe", period_end, 1'b1);
    count_high(5, PERIOD, hi);
    check("write_through_high", hi, exp_high(8'h20, PERIOD));

    // Prescaler period, then lowering prescale mid-count.
    write(ADDR_PRESC, 8'h03);
    wait_pe(4 * PERIOD + 10);
    n = 0;
    do begin
      cyc();
      n++;
    end while (period_end !== 1'b1 && n < 8 * PERIOD);
    check("presc3_period", n, 4 * PERIOD);
    for (int i = 0; i < 8 && m_pcnt != 2; i++) cyc();
    write(ADDR_PRESC, 8'h00);
    cyc();
    wait_pe(PERIOD + 2);

    // Randomised writes against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: write(ADDR_EN_OUT + 7'($urandom_range(0, 2)), 8'($urandom));
          1: write(ADDR_EN_PWM + 7'($urandom_range(0, 2)), 8'($urandom));
          2: write(ADDR_PRESC, 8'($urandom_range(0, 3)));
          6: write(7'($urandom_range(33, 63)), 8'($urandom));
          default: write(ADDR_DUTY + 7'($urandom_range(0, NUM_CH + 1)), 8'($urandom));
        endcase
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
